ram_load_ctrl: RTL and testbench

Write-side sequencer for the per-channel CA-code and navigation-message RAM bank. It parses the 32-bit word stream arriving from the USB3 FIFO into framed load commands. For each command it generates the one-hot write enables, explicit write addresses and write data for the 8 CA RAMs and 8 message RAMs. It also holds the per-channel code-delay registers that feed the read-side delay arithmetic.

---
 rtl/ram_load_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ram_load_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_load_ctrl.sv
// Write-side sequencer for the CA-code / navigation-message RAM bank.
// Parses framed load commands from the stream and drives one-hot RAM writes and code-delay registers.
module ram_load_ctrl #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CA_WORDS    = 32,
  parameter int MSG_WORDS   = 47
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] wr_data,
  output logic [15:0] wren,
  output logic [4:0]  wr_addr_ca,
  output logic [5:0]  wr_addr_msg,
  output logic [9:0]  delay_ca0,
  output logic [9:0]  delay_ca1,
  output logic [9:0]  delay_ca2,
  output logic [9:0]  delay_ca3,
  output logic [9:0]  delay_ca4,
  output logic [9:0]  delay_ca5,
  output logic [9:0]  delay_ca6,
  output logic [9:0]  delay_ca7,
  output logic        busy,
  output logic        load_done,
  output logic        err,
  output logic [15:0] loaded_mask
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t          state_reg;
  state_t          state_next;

  logic            accept;
  logic            hdr_magic_ok;
  logic [1:0]      hdr_type;
  logic [2:0]      hdr_ch;
  logic [9:0]      hdr_delay;
  logic            hdr_bad;
  logic            hdr_load;
  logic            hdr_dly_ok;
  logic            hdr_dly_bad;
  logic            dly_wr;
  logic            last_word;
  logic            tmo_hit;

  logic            is_msg_reg;
  logic [2:0]      ch_reg;
  logic [5:0]      cnt_reg;
  logic [TW-1:0]   tmo_reg;
  logic [31:0]     wr_data_reg;
  logic [15:0]     wren_reg;
  logic [4:0]      wr_addr_ca_reg;
  logic [5:0]      wr_addr_msg_reg;
  logic            err_reg;
  logic [15:0]     loaded_mask_reg;
  logic [9:0]      delay_reg [8];

  assign accept       = in_valid & in_ready;
  assign hdr_magic_ok = (in_data[31:24] == 8'hA5);
  assign hdr_type     = in_data[17:16];
  assign hdr_ch       = in_data[14:12];
  assign hdr_delay    = in_data[9:0];

  assign hdr_bad      = !hdr_magic_ok || (hdr_type == 2'b11);
  assign hdr_load     = !hdr_bad && !hdr_type[1];
  assign hdr_dly_ok   = !hdr_bad && (hdr_type == 2'b10) && (hdr_delay != 10'd1023);
  assign hdr_dly_bad  = !hdr_bad && (hdr_type == 2'b10) && (hdr_delay == 10'd1023);
  assign dly_wr       = (state_reg == IDLE) && accept && hdr_dly_ok;

  assign last_word = (cnt_reg == (is_msg_reg ? 6'(MSG_WORDS - 1) : 6'(CA_WORDS - 1)));
  // Fires on the idle cycle that would bring the counter to TIMEOUT_CYC.
  assign tmo_hit   = !accept && (tmo_reg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (hdr_load) begin
            state_next = LOAD;
          end else if (hdr_dly_ok) begin
            state_next = DONE;
          end
        end
      end
      LOAD: begin
        if (accept && last_word) begin
          state_next = DONE;
        end else if (tmo_hit) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE) || (state_reg == LOAD);
    busy      = (state_reg != IDLE);
    load_done = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_msg_reg      <= 1'b0;
      ch_reg          <= 3'd0;
      cnt_reg         <= 6'd0;
      tmo_reg         <= '0;
      wr_data_reg     <= 32'd0;
      wren_reg        <= 16'd0;
      wr_addr_ca_reg  <= 5'd0;
      wr_addr_msg_reg <= 6'd0;
      err_reg         <= 1'b0;
      loaded_mask_reg <= 16'd0;
    end else begin
      wren_reg <= 16'd0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (hdr_bad || hdr_dly_bad) begin
              err_reg <= 1'b1;
            end
            if (hdr_load) begin
              is_msg_reg <= hdr_type[0];
              ch_reg     <= hdr_ch;
              cnt_reg    <= 6'd0;
              tmo_reg    <= '0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_data_reg <= in_data;
            wren_reg    <= 16'd1 << {is_msg_reg, ch_reg};
            cnt_reg     <= cnt_reg + 6'd1;
            tmo_reg     <= '0;
            if (is_msg_reg) begin
              wr_addr_msg_reg <= cnt_reg;
            end else begin
              wr_addr_ca_reg <= cnt_reg[4:0];
            end
            if (last_word) begin
              loaded_mask_reg[{is_msg_reg, ch_reg}] <= 1'b1;
            end
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
            if (tmo_hit) begin
              err_reg <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // One delay register per channel, written only by an in-range DELAY header.
  for (genvar gi = 0; gi < 8; gi++) begin : g_delay
    always_ff @(posedge clk) begin
      if (rst) begin
        delay_reg[gi] <= 10'd0;
      end else if (dly_wr && (hdr_ch == 3'(gi))) begin
        delay_reg[gi] <= hdr_delay;
      end
    end
  end

  assign wr_data     = wr_data_reg;
  assign wren        = wren_reg;
  assign wr_addr_ca  = wr_addr_ca_reg;
  assign wr_addr_msg = wr_addr_msg_reg;
  assign err         = err_reg;
  assign loaded_mask = loaded_mask_reg;
  assign delay_ca0   = delay_reg[0];
  assign delay_ca1   = delay_reg[1];
  assign delay_ca2   = delay_reg[2];
  assign delay_ca3   = delay_reg[3];
  assign delay_ca4   = delay_reg[4];
  assign delay_ca5   = delay_reg[5];
  assign delay_ca6   = delay_reg[6];
  assign delay_ca7   = delay_reg[7];

endmodule

// File: tb/tb_ram_load_ctrl.sv
// Directed self-checking bench for ram_load_ctrl: loads, delays, bad headers, timeout and mid-load reset.
module tb_ram_load_ctrl;

  localparam int TIMEOUT_CYC = 1024;
  localparam int CA_WORDS    = 32;
  localparam int MSG_WORDS   = 47;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] wr_data;
  logic [15:0] wren;
  logic [4:0]  wr_addr_ca;
  logic [5:0]  wr_addr_msg;
  logic [9:0]  delay_ca0, delay_ca1, delay_ca2, delay_ca3;
  logic [9:0]  delay_ca4, delay_ca5, delay_ca6, delay_ca7;
  logic        busy;
  logic        load_done;
  logic        err;
  logic [15:0] loaded_mask;

  int n_checks = 0;
  int n_errors = 0;

  ram_load_ctrl #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CA_WORDS(CA_WORDS),
    .MSG_WORDS(MSG_WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_data(wr_data),
    .wren(wren),
    .wr_addr_ca(wr_addr_ca),
    .wr_addr_msg(wr_addr_msg),
    .delay_ca0(delay_ca0),
    .delay_ca1(delay_ca1),
    .delay_ca2(delay_ca2),
    .delay_ca3(delay_ca3),
    .delay_ca4(delay_ca4),
    .delay_ca5(delay_ca5),
    .delay_ca6(delay_ca6),
    .delay_ca7(delay_ca7),
    .busy(busy),
    .load_done(load_done),
    .err(err),
    .loaded_mask(loaded_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [1:0] t, input logic [2:0] ch, input logic [9:0] d);
    return {8'hA5, 6'd0, t, 1'b0, ch, 2'b00, d};
  endfunction

  // Sends a CA (t=0) or MSG (t=1) header plus nsend payload words; checks every write.
  task automatic load_cmd(input string name, input logic [1:0] t, input logic [2:0] ch,
                          input int nsend, input int total, input logic [31:0] base, input bit gaps);
    logic [15:0] we;
    we = 16'd1 << {t[0], ch};
    in_valid = 1'b1;
    in_data  = hdr(t, ch, 10'd0);
    @(negedge clk);
    check({name, "_hdr_busy"}, 32'(busy), 32'd1);
    check({name, "_hdr_wren"}, 32'(wren), 32'd0);
    for (int k = 0; k < nsend; k++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(k);
      @(negedge clk);
      check({name, "_wren"}, 32'(wren), 32'(we));
      check({name, "_data"}, wr_data, base + 32'(k));
      if (t[0]) check({name, "_addr_msg"}, 32'(wr_addr_msg), 32'(k));
      else      check({name, "_addr_ca"}, 32'(wr_addr_ca), 32'(k));
      check({name, "_done"}, 32'(load_done), 32'(k == total - 1));
      if (gaps && k < nsend - 1) begin
        in_valid = 1'b0;
        in_data  = 32'hA5A5_A5A5;
        @(negedge clk);
        check({name, "_gap_wren"}, 32'(wren), 32'd0);
      end
    end
    in_valid = 1'b0;
    if (nsend == total) begin
      check({name, "_done_rdy"}, 32'(in_ready), 32'd0);
      check({name, "_done_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_idle_rdy"}, 32'(in_ready), 32'd1);
      check({name, "_idle_done"}, 32'(load_done), 32'd0);
      check({name, "_idle_wren"}, 32'(wren), 32'd0);
    end
    $display("cmd %s type=%0d ch=%0d words=%0d/%0d mask=%h", name, t, ch, nsend, total, loaded_mask);
  endtask

  task automatic send_hdr(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int waited;
    in_valid = 1'b0;
    in_data  = 32'd0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_wren", 32'(wren), 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_addr", {21'd0, wr_addr_msg, wr_addr_ca}, 32'd0);
    check("rst_flags", {29'd0, busy, load_done, err}, 32'd0);
    check("rst_mask", 32'(loaded_mask), 32'd0);
    check("rst_delays", {delay_ca0, delay_ca1, delay_ca2}, 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    $display("reset released");

    load_cmd("ca3", 2'b00, 3'd3, CA_WORDS, CA_WORDS, 32'h1000_0000, 1'b0);
    check("ca3_mask", 32'(loaded_mask), 32'h0008);

    // Payload words carry the magic byte and must still be treated as data.
    load_cmd("msg7", 2'b01, 3'd7, MSG_WORDS, MSG_WORDS, 32'hA500_0000, 1'b1);
    check("msg7_mask", 32'(loaded_mask), 32'h8008);
    check("msg7_ca_addr_hold", 32'(wr_addr_ca), 32'd31);

    send_hdr(hdr(2'b10, 3'd2, 10'd500));
    check("dly500_val", 32'(delay_ca2), 32'd500);
    check("dly500_done", 32'(load_done), 32'd1);
    check("dly500_err", 32'(err), 32'd0);
    check("dly500_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("dly500_idle", 32'(busy), 32'd0);
    $display("cmd delay ch2=500 -> %0d", delay_ca2);

    send_hdr(hdr(2'b10, 3'd6, 10'd1022));
    check("dly1022_val", 32'(delay_ca6), 32'd1022);
    check("dly1022_done", 32'(load_done), 32'd1);
    @(negedge clk);
    $display("cmd delay ch6=1022 -> %0d", delay_ca6);

    send_hdr(hdr(2'b10, 3'd2, 10'd1023));
    check("dly1023_err", 32'(err), 32'd1);
    check("dly1023_val", 32'(delay_ca2), 32'd500);
    check("dly1023_done", 32'(load_done), 32'd0);
    check("dly1023_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("dly1023_err_clr", 32'(err), 32'd0);
    $display("cmd delay ch2=1023 rejected, delay_ca2=%0d", delay_ca2);

    send_hdr(32'h5A00_0000);
    check("badmagic_err", 32'(err), 32'd1);
    check("badmagic_wren", 32'(wren), 32'd0);
    check("badmagic_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("badmagic_err_clr", 32'(err), 32'd0);
    send_hdr(32'hA503_0000);
    check("type11_err", 32'(err), 32'd1);
    check("type11_wren", 32'(wren), 32'd0);
    check("type11_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("type11_err_clr", 32'(err), 32'd0);
    $display("cmd bad headers rejected");

    load_cmd("ca0_part", 2'b00, 3'd0, 10, CA_WORDS, 32'h2000_0000, 1'b0);
    waited = 0;
    for (int i = 1; i <= TIMEOUT_CYC + 20; i++) begin
      @(negedge clk);
      if (err) begin
        waited = i;
        break;
      end
    end
    check("tmo_err_seen", 32'(waited != 0), 32'd1);
    check("tmo_window", 32'(waited >= TIMEOUT_CYC && waited <= TIMEOUT_CYC + 1), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_mask", 32'(loaded_mask), 32'h8008);
    @(negedge clk);
    check("tmo_err_clr", 32'(err), 32'd0);
    $display("cmd timeout after %0d idle cycles", waited);

    load_cmd("ca0_full", 2'b00, 3'd0, CA_WORDS, CA_WORDS, 32'h3000_0000, 1'b0);
    check("ca0_mask", 32'(loaded_mask), 32'h8009);

    load_cmd("msg5_part", 2'b01, 3'd5, 20, MSG_WORDS, 32'h4000_0000, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h4000_0014;
    rst      = 1'b1;
    @(negedge clk);
    check("midrst_wren", 32'(wren), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mask", 32'(loaded_mask), 32'd0);
    check("midrst_data", wr_data, 32'd0);
    check("midrst_addr", {21'd0, wr_addr_msg, wr_addr_ca}, 32'd0);
    check("midrst_flags", {30'd0, load_done, err}, 32'd0);
    check("midrst_delay", {12'd0, delay_ca2, delay_ca6}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_after_wren", 32'(wren), 32'd0);
    check("midrst_after_rdy", 32'(in_ready), 32'd1);
    $display("cmd reset during msg load");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
